// File: rtl/aemb2_mpsram.sv
// Multi-read-port synchronous SRAM with byte-lane writes and a hardware clear sweep.
// Optional same-edge write-to-read bypass: define AEMB2_MPSRAM_BYPASS_EN.
module aemb2_mpsram #(
    parameter int AW = 8,
    parameter int DW = 32,
    parameter int NR = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [AW-1:0]    adr_i,
    input  logic [DW-1:0]    dat_i,
    input  logic [DW/8-1:0]  sel_i,
    input  logic             wre_i,
    input  logic [NR*AW-1:0] xadr_i,
    input  logic [NR-1:0]    xena_i,
    output logic [NR*DW-1:0] xdat_o,
    input  logic             clr_i,
    output logic             bsy_o
);
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          wr_en;
    logic [DW-1:0] mem [DEPTH];

`ifdef AEMB2_MPSRAM_BYPASS_EN
    function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [NB-1:0] sel);
        logic [DW-1:0] res;
        res = old_w;
        for (int b = 0; b < NB; b++) begin
            if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction
`endif

    // Clear sequencer: state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                // clr_i is deliberately ignored here; the sweep runs to completion
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = ST_IDLE;
            end
            default: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    assign bsy_o = (state_q == ST_CLEAR);
    assign wr_en = wre_i && !bsy_o;

    // Array update: the sweep owns the write port while busy
    always_ff @(posedge clk_i) begin
        if (bsy_o) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (sel_i[b]) mem[adr_i][8*b +: 8] <= dat_i[8*b +: 8];
            end
        end
    end

    // Read ports: one register stage from address to xdat_o
    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] radr;
        logic [DW-1:0] rword;
        logic [DW-1:0] rdat_p1;

        assign radr = xadr_i[k*AW +: AW];
`ifdef AEMB2_MPSRAM_BYPASS_EN
        assign rword = (wr_en && (radr == adr_i)) ? merge_lanes(mem[radr], dat_i, sel_i)
                                                  : mem[radr];
`else
        assign rword = mem[radr];
`endif

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                rdat_p1 <= '0;
            end else if (xena_i[k]) begin
                rdat_p1 <= bsy_o ? '0 : rword;
            end
        end

        assign xdat_o[k*DW +: DW] = rdat_p1;
    end

endmodule

// File: doc/aemb2_mpsram.md
# aemb2_mpsram

Single-clock, multi-read-port synchronous SRAM for the AEMB2 core: one byte-enabled write port and NR independent registered read ports. It supersedes the two-port write/read RAM used for register-file and scratch storage. It adds generalised width, depth and read-port count, byte-lane writes, a hardware clear sequencer, and optional write-to-read bypass. It sits under the register file and the local data memory.

## Interface
Parameters:
- AW, 8, address width; depth is 2^AW words.
- DW, 32, data width; must be a multiple of 8.
- NR, 2, number of read ports, 1..4.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- adr_i  in  AW  write address.
- dat_i  in  DW  write data.
- sel_i  in  DW/8  byte-lane write enables; bit b covers dat_i[8b+7:8b].
- wre_i  in  1  write strobe.
- xadr_i  in  NR*AW  read addresses; port k uses slice [k*AW +: AW].
- xena_i  in  NR  per-port read enable.
- xdat_o  out  NR*DW  registered read data; port k uses slice [k*DW +: DW].
- clr_i  in  1  single-cycle request to zero the whole array.
- bsy_o  out  1  high while the clear sequencer runs.

## Operation
- Reset (rst_i low) is asynchronous and forces:
  - all xdat_o to 0;
  - bsy_o to 1;
  - sequencer to CLEAR;
  - clear counter to 0.
- The array contents are not reset directly; they are zeroed by the CLEAR sweep.
- Sequencer states:
  - CLEAR: each edge writes 0 to address cnt, then cnt increments. On the edge where cnt == 2^AW-1, the sequencer writes that address, cnt wraps to 0, state goes to IDLE and bsy_o falls.
  - IDLE: clr_i high on an edge moves the sequencer to CLEAR with cnt=0 and bsy_o=1.
- clr_i while already in CLEAR is ignored; the sweep is not restarted.
- A reset asserted mid-sweep restarts the sweep from address 0 after release.
- Write (IDLE only): when wre_i is high, each lane b with sel_i[b]=1 is updated from dat_i; unselected lanes keep their value. wre_i with sel_i=0 changes nothing. Writes presented while bsy_o=1 are dropped.
- Read port k:
  - When xena_i[k] is high on an edge, xdat_o[k] loads the word at xadr_i[k].
  - When xena_i[k] is low, xdat_o[k] holds its value.
  - While bsy_o=1, an enabled port loads 0.
- Ports are independent. Any number of ports may read the same address in one cycle.
- Read-during-write to the same address is governed by the Configuration macro.

## Timing
- Read latency is 1 cycle: data for an address presented at edge n is valid after edge n.
- Write latency is 1 cycle: data written at edge n is readable by a read launched at edge n+1.
- Clear duration is exactly 2^AW edges. After rst_i rises, bsy_o is high for 2^AW rising edges (256 with AW=8) and is low after the 2^AW-th edge.
- After clr_i is sampled in IDLE, bsy_o is high from the next edge for 2^AW edges.
- bsy_o is a registered output with no combinational path from inputs.
- Read address to xdat_o is register-only; there is no async read path.

## Configuration
- AEMB2_MPSRAM_BYPASS_EN defined:
  - A read and a write to the same address on the same edge returns the new data in selected lanes and old data in unselected lanes.
  - The same applies to every port with a matching address.
- AEMB2_MPSRAM_BYPASS_EN undefined:
  - Same-edge read returns the old word in all lanes (read-before-write).
  - No compare or merge logic is built.

## Test plan
- Reset, then release; read addresses 0, 0x80 and 0xFF on ports 0 and 1 at edge 2^AW+1 -> bsy_o high for exactly 256 edges, xdat_o=0 throughout, reads return 0x00000000.
- Write 0xDEADBEEF to 0x10 with sel_i=4'hF, then write 0x11223344 to 0x10 with sel_i=4'b0101; read 0x10 -> 0xDE22BE44.
- Issue clr_i after memory is filled, then re-issue clr_i at sweep cycle 100 -> sweep finishes 256 edges after the first clr_i. Writes issued during the sweep are dropped. All addresses read 0.
- Write 0xCAFEF00D to 0x20 with sel_i=4'b0011 while port 0 reads 0x20 (old value 0x12345678) on the same edge:
  - BYPASS_EN defined -> 0x1234F00D.
  - BYPASS_EN undefined -> 0x12345678.
- Port 0 reads 0x05 with xena_i[0]=1, then xena_i[0]=0 for 3 cycles while 0x05 is rewritten -> xdat_o port 0 holds the old value.
- Assert rst_i mid-read at sweep cycle 50 -> xdat_o=0 and bsy_o=1 immediately (asynchronously), and the sweep restarts at address 0.
